// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI arbiter.
package cpu_axi_pkg;

    // Transaction FSM states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        B    = 3'd4
    } state_t;

    // Which CPU port owns the current transaction.
    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    // Every beat is one 32-bit word.
    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

endpackage

// File: rtl/cpu_axi_arbiter_if.sv
// AXI master-side channel bundle driven by the arbiter (single beat, 32-bit).
interface cpu_axi_arbiter_if;

    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arsize, arvalid, input  arready,
        input  rdata, rvalid,           output rready,
        output awaddr, awsize, awvalid, input  awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bvalid,                  output bready
    );

    modport slave (
        input  araddr, arsize, arvalid, output arready,
        output rdata, rvalid,           input  rready,
        input  awaddr, awsize, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bvalid,                  input  bready
    );

endinterface

// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter: shares one AXI master port between the instruction-fetch
// and load/store ports, one outstanding transaction at a time. All AXI
// outputs come from registers latched at grant time.
// Build option: define ARB_RR_EN for round-robin tie-breaking; otherwise the
// data port always wins a tie.
module cpu_axi_arbiter
    import cpu_axi_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [31:0]       data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_data_ok,
    output logic              i_stall,
    output logic              d_stall,
    cpu_axi_arbiter_if.master axi
);

    state_t      state;
    grant_t      grant_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        wr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    grant_t      tie_winner;
    grant_t      pick;
    logic        done;

    // Tie-break: fixed data priority, or a pointer naming the port that wins
    // the next tie (starts at data, flips away from whoever was just granted).
`ifdef ARB_RR_EN
    grant_t prio_q;
    assign tie_winner = prio_q;
`else
    assign tie_winner = GRANT_DATA;
`endif

    function automatic grant_t arb_select(input logic i_req, input logic d_req,
                                          input grant_t tie);
        if (i_req && d_req) return tie;
        if (d_req)          return GRANT_DATA;
        return GRANT_INST;
    endfunction

    assign pick = arb_select(inst_req, data_req, tie_winner);

    // Transaction FSM: grant and latch in IDLE, then walk the AXI handshakes.
    // NOTE: the whole FSM including the latched request is cleared by the
    // asynchronous reset; there is no memory here that could be left unreset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            grant_q   <= GRANT_INST;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_q      <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef ARB_RR_EN
            prio_q    <= GRANT_DATA;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // samples the pre-edge value of its neighbours.
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        grant_q <= pick;
                        if (pick == GRANT_DATA) begin
                            addr_q  <= data_addr;
                            wdata_q <= data_wdata;
                            wstrb_q <= data_wstrb;
                            wr_q    <= data_wr;
                        end else begin
                            addr_q  <= inst_addr;
                            wdata_q <= '0;
                            wstrb_q <= '0;
                            wr_q    <= 1'b0;
                        end
                        if (pick == GRANT_DATA && data_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= AR;
                        end
`ifdef ARB_RR_EN
                        prio_q <= (pick == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
`endif
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                AW: begin
                    // Address and data channels retire independently.
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
                        bready_q <= 1'b1;
                        state    <= B;
                    end
                end
                B: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is the final handshake of the read or write response.
    assign done         = (rready_q && axi.rvalid) || (bready_q && axi.bvalid);
    assign inst_data_ok = done && (grant_q == GRANT_INST);
    assign data_data_ok = done && (grant_q == GRANT_DATA);
    assign inst_rdata   = (grant_q == GRANT_INST) ? axi.rdata : '0;
    assign data_rdata   = (grant_q == GRANT_DATA) ? axi.rdata : '0;
    assign i_stall      = inst_req && !inst_data_ok;
    assign d_stall      = data_req && !data_data_ok;

    assign axi.araddr   = addr_q;
    assign axi.arsize   = AXI_SIZE_WORD;
    assign axi.arvalid  = arvalid_q;
    assign axi.rready   = rready_q;
    assign axi.awaddr   = addr_q;
    assign axi.awsize   = AXI_SIZE_WORD;
    assign axi.awvalid  = awvalid_q;
    assign axi.wdata    = wdata_q;
    assign axi.wstrb    = wstrb_q;
    assign axi.wlast    = 1'b1;
    assign axi.wvalid   = wvalid_q;
    assign axi.bready   = bready_q;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Self-checking bench for cpu_axi_arbiter: acts as both CPU ports and an AXI
// slave with configurable or random latencies, and compares against a
// transaction-level model of grant order, handshake sequencing and completion.
module tb_cpu_axi_arbiter;

    localparam int I = 0;
    localparam int D = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, inst_data_ok, data_req, data_wr, data_data_ok;
    logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        i_stall, d_stall;

    always #5 clk = ~clk;

    cpu_axi_arbiter_if axi ();

    cpu_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_data_ok(data_data_ok),
        .i_stall(i_stall), .d_stall(d_stall),
        .axi(axi)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester state, per port.
    logic        req_v[2];
    logic [31:0] addr_v[2];
    logic        wr_v[2];
    logic [3:0]  wstrb_v[2];
    logic [31:0] wdata_v[2];
    bit          inflight[2];
    bit          done_prev[2];
    int          ok_cnt[2];
    int          ok_cycle[2];

    // Arbiter model: free, granted (AXI valid expected next cycle), busy.
    typedef enum {M_FREE, M_ISSUE, M_BUSY} mphase_t;
    mphase_t     phase;
    int          g;
    logic [31:0] x_addr, x_wdata;
    logic [3:0]  x_wstrb;
    logic        x_wr;
    bit          prio_data;
    int          grant_log[$];
    int          inst_issue_cycle;

    // Slave model.
    bit          ar_done, aw_done, w_done;
    int          ar_cnt, aw_cnt, w_cnt, wait_cnt;
    int          ar_lat, r_lat, aw_lat, w_lat, b_lat;
    logic [31:0] rd_val;
    bit          rand_lat, gen_en, auto_renew, w_first_seen;
    int          cycle = 0;

    task automatic drive_cpu();
        inst_req   = req_v[I];
        inst_addr  = addr_v[I];
        data_req   = req_v[D];
        data_wr    = wr_v[D];
        data_addr  = addr_v[D];
        data_wstrb = wstrb_v[D];
        data_wdata = wdata_v[D];
    endtask

    task automatic issue(input int r, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] wd);
        req_v[r]   = 1'b1;
        addr_v[r]  = a;
        wr_v[r]    = (r == D) ? w : 1'b0;
        wstrb_v[r] = s;
        wdata_v[r] = wd;
    endtask

    task automatic random_req(input int r);
        issue(r, $urandom, ($urandom_range(0, 1) == 1), 4'($urandom_range(1, 15)), $urandom);
    endtask

    task automatic new_txn();
        ar_done = 0; aw_done = 0; w_done = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; wait_cnt = 0;
        if (rand_lat) begin
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            b_lat  = $urandom_range(0, 3); rd_val = $urandom;
        end
    endtask

    task automatic clear_axi_inputs();
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    endtask

    task automatic model_reset();
        phase = M_FREE; prio_data = 1;
        for (int r = 0; r < 2; r++) begin
            inflight[r] = 0; done_prev[r] = 0;
        end
        ar_done = 0; aw_done = 0; w_done = 0; wait_cnt = 0;
        clear_axi_inputs();
    endtask

    // One clock cycle of CPU, slave and model activity, starting at negedge.
    task automatic step();
        logic [4:0] hs_got, hs_exp;
        logic [1:0] exp_ok;
        logic       rv, bv, ar, awr, wr;
        bit         comp;
        @(negedge clk);
        cycle++;
        // CPU ports: retire, renew, create or abandon requests.
        for (int r = 0; r < 2; r++) begin
            if (done_prev[r]) begin
                done_prev[r] = 0;
                if (auto_renew) addr_v[r] = $urandom;
                else            req_v[r]  = 1'b0;
            end
            if (gen_en) begin
                if (!req_v[r] && !inflight[r] && $urandom_range(0, 2) == 0)
                    random_req(r);
                else if (inflight[r] && req_v[r] && $urandom_range(0, 4) == 0) begin
                    req_v[r] = 1'b0; addr_v[r] = $urandom; wdata_v[r] = $urandom;
                end
            end
        end
        drive_cpu();
        // Registered AXI outputs against the expected handshake progress.
        hs_got = {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
        if (phase == M_FREE) begin
            check("axi_idle", hs_got, 5'b0);
        end else begin
            if (phase == M_ISSUE) begin
                phase = M_BUSY;
                if (g == I) inst_issue_cycle = cycle;
            end
            hs_exp = {!x_wr && !ar_done, !x_wr && ar_done, x_wr && !aw_done,
                      x_wr && !w_done, x_wr && aw_done && w_done};
            check("axi_handshake", hs_got, hs_exp);
            if (axi.arvalid) check("araddr", axi.araddr, x_addr);
            if (axi.awvalid) check("awaddr", axi.awaddr, x_addr);
            if (axi.wvalid) begin
                check("wdata", axi.wdata, x_wdata);
                check("wstrb", axi.wstrb, x_wstrb);
            end
            if (axi.awvalid && !axi.wvalid) w_first_seen = 1;
        end
        // Slave responses.
        rv = 0; bv = 0;
        if (phase == M_BUSY && !x_wr && ar_done) begin
            if (wait_cnt == 0) rv = 1; else wait_cnt--;
        end
        if (phase == M_BUSY && x_wr && aw_done && w_done) begin
            if (wait_cnt == 0) bv = 1; else wait_cnt--;
        end
        ar = 0; awr = 0; wr = 0;
        if (axi.arvalid) begin ar  = (ar_cnt >= ar_lat); ar_cnt++; end
        if (axi.awvalid) begin awr = (aw_cnt >= aw_lat); aw_cnt++; end
        if (axi.wvalid)  begin wr  = (w_cnt  >= w_lat);  w_cnt++;  end
        axi.arready = ar; axi.awready = awr; axi.wready = wr;
        axi.rvalid  = rv; axi.bvalid  = bv;
        axi.rdata   = rv ? rd_val : $urandom;
        if (axi.arvalid && ar) begin ar_done = 1; wait_cnt = r_lat; end
        if (axi.awvalid && awr) begin aw_done = 1; wait_cnt = b_lat; end
        if (axi.wvalid && wr)   begin w_done  = 1; wait_cnt = b_lat; end
        // Completion pulses, passthrough data and stall equations.
        #1;
        exp_ok = 2'b00;
        comp = (phase == M_BUSY) && ((rv && axi.rready) || (bv && axi.bready));
        if (comp) exp_ok[g] = 1'b1;
        check("inst_data_ok", inst_data_ok, exp_ok[I]);
        check("data_data_ok", data_data_ok, exp_ok[D]);
        if (comp && !x_wr) begin
            if (g == I) check("inst_rdata", inst_rdata, rd_val);
            else        check("data_rdata", data_rdata, rd_val);
        end
        check("i_stall", i_stall, inst_req && !exp_ok[I]);
        check("d_stall", d_stall, data_req && !exp_ok[D]);
        if (comp) begin
            ok_cnt[g]++; ok_cycle[g] = cycle;
            inflight[g] = 0; done_prev[g] = 1; phase = M_FREE;
        end else if (phase == M_FREE && (req_v[I] || req_v[D])) begin
            if (req_v[I] && req_v[D]) g = prio_data ? D : I;
            else                      g = req_v[D] ? D : I;
            x_addr = addr_v[g]; x_wr = (g == D) ? wr_v[D] : 1'b0;
            x_wdata = wdata_v[g]; x_wstrb = wstrb_v[g];
            inflight[g] = 1; phase = M_ISSUE;
            grant_log.push_back(g);
`ifdef ARB_RR_EN
            prio_data = (g == I);
`endif
            new_txn();
        end
    endtask

    task automatic run_until_quiet(input int budget);
        int n = 0;
        while ((req_v[I] || req_v[D] || inflight[I] || inflight[D] || phase != M_FREE)
               && n < budget) begin
            step(); n++;
        end
        check("settle", {req_v[I], req_v[D], inflight[I], inflight[D]}, 4'b0);
    endtask

    task automatic step_until_ok(input string tag, input int r, input int budget);
        int base = ok_cnt[r];
        int n = 0;
        while (ok_cnt[r] == base && n < budget) begin step(); n++; end
        check(tag, ok_cnt[r] - base, 1);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_axi_inputs();
        #1;
        check("rst_handshake", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b0);
        check("rst_ok", {inst_data_ok, data_data_ok}, 2'b0);
        check("rst_latched", {axi.araddr, axi.wstrb, axi.wdata[27:0]}, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        int base, n;
        logic [31:0] sv_addr;
        for (int r = 0; r < 2; r++) begin
            req_v[r] = 0; addr_v[r] = '0; wr_v[r] = 0; wstrb_v[r] = '0; wdata_v[r] = '0;
            ok_cnt[r] = 0; ok_cycle[r] = 0;
        end
        gen_en = 0; auto_renew = 0; rand_lat = 0; rd_val = '0; w_first_seen = 0;
        ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0;
        drive_cpu();
        apply_reset();
        check("arsize", axi.arsize, 3'b010);
        check("awsize", axi.awsize, 3'b010);
        check("wlast", axi.wlast, 1'b1);

        // Lone fetch: arready on the second AR cycle, rvalid two cycles into R.
        ar_lat = 1; r_lat = 2; rd_val = 32'h3C1D0001;
        issue(I, 32'hBFC00000, 1'b0, 4'h0, 32'h0);
        base = cycle + 1;
        step_until_ok("fetch_done", I, 20);
        check("fetch_latency", ok_cycle[I] - base, 5);
        run_until_quiet(10);

        // Simultaneous fetch and load.
        ar_lat = 0; r_lat = 0; rd_val = 32'h1234ABCD;
        base = grant_log.size();
        issue(I, 32'hBFC00010, 1'b0, 4'h0, 32'h0);
        issue(D, 32'h80000020, 1'b0, 4'hF, 32'h0);
        run_until_quiet(30);
`ifndef ARB_RR_EN
        check("tie_first_data", grant_log[base], D);
        check("tie_second_inst", grant_log[base + 1], I);
        check("fetch_after_load", inst_issue_cycle - ok_cycle[D], 2);
`endif

        // Store with wready two cycles ahead of awready.
        aw_lat = 2; w_lat = 0; b_lat = 1; w_first_seen = 0;
        base = ok_cnt[D];
        issue(D, 32'h80001000, 1'b1, 4'b0011, 32'hA5A51234);
        run_until_quiet(30);
        check("store_ok_once", ok_cnt[D] - base, 1);
        check("wvalid_first", w_first_seen, 1'b1);

        // Random traffic with mid-transaction request drops.
        rand_lat = 1; gen_en = 1;
        for (int k = 0; k < 500; k++) step();
        gen_en = 0;
        run_until_quiet(200);

        // Reset while in R, then the held fetch restarts from IDLE.
        rand_lat = 0; ar_lat = 0; r_lat = 6; rd_val = 32'h0BADF00D;
        sv_addr = 32'h10000040;
        issue(I, sv_addr, 1'b0, 4'h0, 32'h0);
        n = 0;
        while (axi.rready !== 1'b1 && n < 10) begin step(); n++; end
        check("reached_r", axi.rready, 1'b1);
        base = ok_cnt[I];
        axi.rvalid = 1'b1; axi.rdata = rd_val;
        resetn = 1'b0;
        #1;
        check("rst_in_r_axi", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b0);
        check("rst_in_r_ok", {inst_data_ok, data_data_ok}, 2'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
        r_lat = 1;
        step_until_ok("restart_done", I, 30);
        check("restart_single_ok", ok_cnt[I] - base, 1);
        run_until_quiet(10);

`ifdef ARB_RR_EN
        // Round-robin with both ports continuously requesting.
        apply_reset();
        ar_lat = 0; r_lat = 0; auto_renew = 1;
        base = grant_log.size();
        issue(I, 32'hBFC00100, 1'b0, 4'h0, 32'h0);
        issue(D, 32'h80000100, 1'b0, 4'hF, 32'h0);
        n = 0;
        while (grant_log.size() < base + 4 && n < 60) begin step(); n++; end
        auto_renew = 0;
        run_until_quiet(60);
        for (int k = 0; k < 4; k++)
            check("rr_order", grant_log[base + k], (k % 2 == 0) ? D : I);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
